tristate_bus_arbiter: RTL and testbench

- Round-robin arbiter for the shared tristate data bus of the RISC-Y datapath.
- Takes NREQ bus requests and issues one-hot grants. Drives the CTRL enable of each requester's tristate buffer (OE).
- Guarantees that at most one driver is enabled at any time.
- Inserts an all-off turnaround gap between owners so no two drivers overlap on the bus.

---
 rtl/tristate_bus_arbiter_pkg.sv | 25 ++
 rtl/tristate_bus_arbiter_if.sv | 24 ++
 rtl/tristate_bus_arbiter_rr_picker.sv | 36 +++
 rtl/tristate_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and defaults for the tristate bus arbiter.
// Contents:
//   arb_state_t  - arbiter FSM state encoding (IDLE / GRANT / TURN)
//   DEF_*        - default parameter values used by the interface and the RTL
//   wrap_inc()   - modulo-n increment used to rotate the priority pointer
package tristate_bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_TURN  = 2'd2
    } arb_state_t;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_MAX_HOLD = 8;
    localparam int DEF_TURN_CYC = 1;

    // Next index after v, wrapping back to 0 at n.
    function automatic int wrap_inc(input int v, input int n);
        int r;
        r = v + 32'sd1;
        return (r >= n) ? 32'sd0 : r;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Bus-arbitration interface between the requesters and the arbiter.
// Signals:
//   req   - one request bit per requester (level, held until done)
//   gnt   - one-hot or zero grant vector
//   oe    - tristate CTRL enables, identical to gnt
//   busy  - bus granted or turnaround in progress
//   owner - index of the current or most recent owner
// Modports: master = arbiter side, slave = requester side.
interface tristate_bus_arbiter_if
    import tristate_bus_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] oe;
    logic            busy;
    logic [IW-1:0]   owner;

    modport master (input req, output gnt, output oe, output busy, output owner);
    modport slave  (output req, input gnt, input oe, input busy, input owner);
endinterface

// File: rtl/tristate_bus_arbiter_rr_picker.sv
// Combinational round-robin winner search.
// Ports:
//   req_i   - request vector
//   ptr_i   - index checked first; the scan wraps modulo NREQ
//   valid_o - at least one request is set
//   win_o   - index of the first set request at or after ptr_i
module rr_picker
    import tristate_bus_arb_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [IW-1:0]   win_o
);

    int   idx_s;
    logic hit_s;

    // Scan from the farthest offset down to offset 0 so the closest hit to ptr_i is written last.
    always_comb begin
        valid_o = 1'b0;
        win_o   = {IW{1'b0}};
        idx_s   = 32'sd0;
        hit_s   = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_s   = (int'(ptr_i) + k) % NREQ;
            hit_s   = req_i[IW'(idx_s)];
            valid_o = valid_o | hit_s;
            win_o   = hit_s ? IW'(idx_s) : win_o;
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tristate data bus.
// Issues one-hot grants, drives each requester's tristate enable (oe == gnt)
// and inserts TURN_CYC all-off cycles between owners so drivers never overlap.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - tristate_bus_arbiter_if.master (req in; gnt, oe, busy, owner out)
// Parameters: NREQ requesters (2..8), MAX_HOLD cycles an owner may keep the
// bus while someone else waits (>=1), TURN_CYC turnaround cycles (1..4).
module tristate_bus_arbiter
    import tristate_bus_arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tristate_bus_arbiter_if.master bus
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [HW-1:0]   hold_q,  hold_d;
    logic [TW-1:0]   turn_q,  turn_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic            busy_q,  busy_d;
    logic [IW-1:0]   owner_q, owner_d;

    logic            pick_valid_s;
    logic [IW-1:0]   pick_win_s;
    logic            owner_req_s;
    logic            others_req_s;
    logic            hold_limit_s;
    logic            turn_last_s;
    logic [NREQ-1:0] win_onehot_s;

    // One picker serves both the IDLE and the last-TURN-cycle decisions; ptr_q
    // is already rotated by the time the TURN decision is made.
    rr_picker #(.NREQ(NREQ)) u_picker (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid_s),
        .win_o   (pick_win_s)
    );

    // In GRANT, gnt_q is the owner's one-hot mask, so it splits req into owner/others.
    assign owner_req_s  = |(bus.req & gnt_q);
    assign others_req_s = |(bus.req & ~gnt_q);
    // ">=" rather than "==" so a saturated hold still yields to a newcomer.
    assign hold_limit_s = (hold_q >= HW'(MAX_HOLD - 1));
    assign turn_last_s  = (turn_q == TW'(TURN_CYC - 1));
    assign win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << pick_win_s;

    // Next-state and registered-output decode for the IDLE/GRANT/TURN FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        owner_d = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ARB_GRANT;
                    gnt_d   = win_onehot_s;
                    owner_d = pick_win_s;
                    busy_d  = 1'b1;
                    hold_d  = {HW{1'b0}};
                end else begin
                    gnt_d  = {NREQ{1'b0}};
                    busy_d = 1'b0;
                end
            end
            ARB_GRANT: begin
                // A REQ drop coinciding with a forced release takes the same path.
                if (!owner_req_s || (hold_limit_s && others_req_s)) begin
                    state_d = ARB_TURN;
                    gnt_d   = {NREQ{1'b0}};
                    busy_d  = 1'b1;
                    turn_d  = {TW{1'b0}};
                    ptr_d   = IW'(wrap_inc(int'(owner_q), NREQ));
                end else begin
                    hold_d = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + HW'(1);
                end
            end
            ARB_TURN: begin
                if (turn_last_s) begin
                    if (pick_valid_s) begin
                        state_d = ARB_GRANT;
                        gnt_d   = win_onehot_s;
                        owner_d = pick_win_s;
                        busy_d  = 1'b1;
                        hold_d  = {HW{1'b0}};
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = {NREQ{1'b0}};
                        busy_d  = 1'b0;
                    end
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = {NREQ{1'b0}};
                busy_d  = 1'b0;
                hold_d  = {HW{1'b0}};
                turn_d  = {TW{1'b0}};
            end
        endcase
    end

    // State and output registers; reset clears grants immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= {IW{1'b0}};
            hold_q  <= {HW{1'b0}};
            turn_q  <= {TW{1'b0}};
            gnt_q   <= {NREQ{1'b0}};
            busy_q  <= 1'b0;
            owner_q <= {IW{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

    // OE is the grant register itself, so the two can never disagree.
    assign bus.gnt   = gnt_q;
    assign bus.oe    = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter: two instances (default timing and
// a long-turnaround / short-hold variant) share the same request stimulus.
module tb_tristate_bus_arbiter;

    localparam int N      = 4;
    localparam int A_HOLD = 8;
    localparam int A_TURN = 1;
    localparam int B_HOLD = 3;
    localparam int B_TURN = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tristate_bus_arbiter_if #(.NREQ(N)) bus_a ();
    tristate_bus_arbiter_if #(.NREQ(N)) bus_b ();

    tristate_bus_arbiter #(.NREQ(N), .MAX_HOLD(A_HOLD), .TURN_CYC(A_TURN)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    tristate_bus_arbiter #(.NREQ(N), .MAX_HOLD(B_HOLD), .TURN_CYC(B_TURN)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Reference model: who owns the bus, how long they have had it, how many
    // turnaround cycles remain, and which requester is checked first.
    typedef struct {
        int owner;
        int held;
        int gap;
        int ptr;
        bit granted;
    } mdl_t;

    typedef struct {
        int ga; int ba; int oa;
        int gb; int bb; int ob;
    } exp_t;

    int   vectors     = 0;
    int   miscompares = 0;
    mdl_t ma, mb;
    exp_t exp_q[$];
    exp_t mon_e;
    int   zrun[2];
    int   lown[2];

    function automatic mdl_t mdl_init();
        mdl_t m;
        m.owner = 0; m.held = 0; m.gap = 0; m.ptr = 0; m.granted = 1'b0;
        return m;
    endfunction

    function automatic int pick(logic [3:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One clock of arbitration given the request vector sampled at that edge.
    function automatic mdl_t step(mdl_t m, logic [3:0] r, int maxh, int turnc);
        mdl_t n;
        int   w;
        logic [3:0] others;
        n = m;
        if (m.granted) begin
            others = r & ~(4'b0001 << m.owner);
            if (!r[m.owner] || (m.held >= maxh - 1 && others != 4'b0000)) begin
                n.granted = 1'b0;
                n.gap     = turnc;
                n.ptr     = (m.owner + 1) % N;
            end else begin
                n.held = (m.held + 1 > maxh) ? maxh : m.held + 1;
            end
        end else if (m.gap > 1) begin
            n.gap = m.gap - 1;
        end else begin
            n.gap = 0;
            w = pick(r, m.ptr);
            if (w >= 0) begin
                n.granted = 1'b1;
                n.owner   = w;
                n.held    = 0;
            end
        end
        return n;
    endfunction

    task automatic chk(string nm, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Drive one cycle of requests and queue the response expected after the next edge.
    task automatic drive(logic [3:0] r);
        exp_t e;
        @(negedge clk);
        bus_a.req = r;
        bus_b.req = r;
        ma = step(ma, r, A_HOLD, A_TURN);
        mb = step(mb, r, B_HOLD, B_TURN);
        e.ga = ma.granted ? (1 << ma.owner) : 0;
        e.ba = (ma.granted || ma.gap > 0) ? 1 : 0;
        e.oa = ma.owner;
        e.gb = mb.granted ? (1 << mb.owner) : 0;
        e.bb = (mb.granted || mb.gap > 0) ? 1 : 0;
        e.ob = mb.owner;
        exp_q.push_back(e);
    endtask

    task automatic drive_n(logic [3:0] r, int n);
        for (int i = 0; i < n; i++) drive(r);
    endtask

    // Bus invariants: one-hot grant, OE tracks GNT, and enough dead cycles between owners.
    task automatic inv(int id, logic [3:0] g, logic [3:0] o, int turnc);
        int own;
        chk(id == 0 ? "onehot0_a" : "onehot0_b", int'($onehot0(g)), 1);
        chk(id == 0 ? "oe_eq_gnt_a" : "oe_eq_gnt_b", int'(o), int'(g));
        if (g == 4'b0000) begin
            zrun[id]++;
        end else begin
            own = 0;
            for (int k = 0; k < N; k++) if (g[k]) own = k;
            if (lown[id] >= 0 && own != lown[id])
                chk(id == 0 ? "turn_gap_a" : "turn_gap_b", (zrun[id] >= turnc) ? 1 : 0, 1);
            zrun[id] = 0;
            lown[id] = own;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_gnt_a",   int'(bus_a.gnt),   0);
        chk("rst_oe_a",    int'(bus_a.oe),    0);
        chk("rst_busy_a",  int'(bus_a.busy),  0);
        chk("rst_owner_a", int'(bus_a.owner), 0);
        chk("rst_gnt_b",   int'(bus_b.gnt),   0);
        chk("rst_oe_b",    int'(bus_b.oe),    0);
        chk("rst_busy_b",  int'(bus_b.busy),  0);
    endtask

    // Pulse reset in the middle of a cycle and check that outputs clear before any edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        ma = mdl_init();
        mb = mdl_init();
        exp_q.delete();
        zrun[0] = 0; zrun[1] = 0;
        lown[0] = -1; lown[1] = -1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: after each edge pop the expected response and compare.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("gnt_a",   int'(bus_a.gnt),   mon_e.ga);
            chk("busy_a",  int'(bus_a.busy),  mon_e.ba);
            chk("owner_a", int'(bus_a.owner), mon_e.oa);
            chk("gnt_b",   int'(bus_b.gnt),   mon_e.gb);
            chk("busy_b",  int'(bus_b.busy),  mon_e.bb);
            chk("owner_b", int'(bus_b.owner), mon_e.ob);
            inv(0, bus_a.gnt, bus_a.oe, A_TURN);
            inv(1, bus_b.gnt, bus_b.oe, B_TURN);
        end
    end

    initial begin
        logic [3:0] r;
        bus_a.req = 4'b0000;
        bus_b.req = 4'b0000;
        ma = mdl_init();
        mb = mdl_init();
        zrun[0] = 0; zrun[1] = 0;
        lown[0] = -1; lown[1] = -1;

        #2;
        chk_reset_outputs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Single requester, then release with one turnaround cycle.
        drive_n(4'b0100, 3);
        drive_n(4'b0000, 5);

        // Everyone requesting: rotation with forced releases.
        drive_n(4'b1111, 40);
        drive_n(4'b0000, 6);

        // Reset while requester 1 owns the bus, then arbitration restarts at 0.
        drive_n(4'b0010, 3);
        do_reset();
        drive_n(4'b0110, 4);
        drive_n(4'b0000, 4);

        // Owner drops REQ in the very cycle a forced release would trigger.
        drive_n(4'b0011, 8);
        drive_n(4'b0010, 6);
        drive_n(4'b0000, 6);

        // Lone requester keeps the bus past MAX_HOLD, then yields to a newcomer.
        drive_n(4'b0001, 20);
        drive_n(4'b1001, 12);
        drive_n(4'b0000, 6);

        // Random request patterns held for random lengths.
        for (int i = 0; i < 120; i++) begin
            r = 4'($urandom_range(0, 15));
            drive_n(r, $urandom_range(1, 12));
        end
        drive_n(4'b0000, 8);

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
